// File: rtl/fp_div_issue.sv
// rtl/fp_div_issue.sv - issue/retire controller for the iterative fp32 divider
// Resolves specials and exponent range locally; normal operands go to the divider.
module fp_div_issue #(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] QNAN           = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        div_start,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_done,
    input  logic [31:0] div_r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_r,
    output logic [4:0]  out_flags,
    output logic        busy
);
    localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          div_start_q;
    logic [31:0]   div_a_q;
    logic [31:0]   div_b_q;
    logic          out_valid_q;
    logic [31:0]   out_r_q;
    logic [4:0]    out_flags_q;

    logic               sgn;
    logic               a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    logic signed [9:0]  exp_d;
    logic               byp_d;
    logic [31:0]        byp_r_d;
    logic [4:0]         byp_f_d;
    logic [31:0]        post_r_d;
    logic [4:0]         post_f_d;

    // Exponent field 0 covers both zero and denormal, which flush to zero.
    always_comb begin
        sgn    = in_a[31] ^ in_b[31];
        a_nan  = (in_a[30:23] == 8'hFF) && (in_a[22:0] != 23'd0);
        a_inf  = (in_a[30:23] == 8'hFF) && (in_a[22:0] == 23'd0);
        a_zero = (in_a[30:23] == 8'h00);
        b_nan  = (in_b[30:23] == 8'hFF) && (in_b[22:0] != 23'd0);
        b_inf  = (in_b[30:23] == 8'hFF) && (in_b[22:0] == 23'd0);
        b_zero = (in_b[30:23] == 8'h00);
        exp_d  = $signed({2'b00, in_a[30:23]}) - $signed({2'b00, in_b[30:23]}) + 10'sd127;
        byp_d   = 1'b1;
        byp_r_d = QNAN;
        byp_f_d = 5'b00000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            byp_r_d = QNAN;
            byp_f_d = 5'b10000;
        end else if (a_inf) begin
            byp_r_d = {sgn, 8'hFF, 23'd0};
        end else if (b_inf) begin
            byp_r_d = {sgn, 31'd0};
        end else if (b_zero) begin
            byp_r_d = {sgn, 8'hFF, 23'd0};
            byp_f_d = 5'b01000;
        end else if (a_zero) begin
            byp_r_d = {sgn, 31'd0};
        end else if (exp_d >= 10'sd256) begin
            byp_r_d = {sgn, 8'hFF, 23'd0};
            byp_f_d = 5'b00100;
        end else if (exp_d <= 10'sd0) begin
            byp_r_d = {sgn, 31'd0};
            byp_f_d = 5'b00010;
        end else begin
            byp_d = 1'b0;
        end
    end

    always_comb begin
        post_r_d = div_r;
        post_f_d = 5'b00000;
        if (div_r[30:23] == 8'hFF) begin
            post_r_d = {div_r[31], 8'hFF, 23'd0};
            post_f_d = 5'b00100;
        end else if (div_r[30:23] == 8'h00) begin
            post_r_d = {div_r[31], 31'd0};
            post_f_d = 5'b00010;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            div_start_q <= 1'b0;
            div_a_q     <= 32'd0;
            div_b_q     <= 32'd0;
            out_valid_q <= 1'b0;
            out_r_q     <= 32'd0;
            out_flags_q <= 5'd0;
        end else begin
            div_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        div_a_q <= in_a;
                        div_b_q <= in_b;
                        if (byp_d) begin
                            out_r_q     <= byp_r_d;
                            out_flags_q <= byp_f_d;
                            out_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            div_start_q <= 1'b1;
                            state_q     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the last counted cycle still wins.
                    if (div_done) begin
                        out_r_q     <= post_r_d;
                        out_flags_q <= post_f_d;
                        out_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        out_r_q     <= QNAN;
                        out_flags_q <= 5'b10001;
                        out_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_r_q     <= 32'd0;
                        out_flags_q <= 5'd0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign div_start = div_start_q;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign out_valid = out_valid_q;
    assign out_r     = out_r_q;
    assign out_flags = out_flags_q;
endmodule

// File: tb/tb_fp_div_issue.sv
// tb/tb_fp_div_issue.sv - scoreboard bench for fp_div_issue with a simple divider model
module tb_fp_div_issue;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = 32'd0;
    logic [31:0] in_b = 32'd0;
    logic        div_start;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_done = 1'b0;
    logic [31:0] div_r = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_r;
    logic [4:0]  out_flags;
    logic        busy;

    fp_div_issue dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_done(div_done), .div_r(div_r),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_flags(out_flags),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_push = 0;
    int n_pop = 0;
    int n_starts = 0;
    logic [36:0] exp_q[$];

    logic        model_en = 1'b0;
    int          model_lat = 6;
    logic [31:0] model_r = 32'd0;
    logic [31:0] exp_a = 32'd0;
    logic [31:0] exp_b = 32'd0;
    logic        ops_chk = 1'b1;

    task automatic check(input string name, input logic [36:0] act, input logic [36:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        if (div_start) n_starts++;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got %h_%b expected none", out_r, out_flags);
            end else begin
                check("result", {out_r, out_flags}, exp_q.pop_front());
                n_pop++;
            end
        end
    end

    // Divider model: answers model_lat cycles after sampling div_start.
    initial begin
        forever begin
            @(posedge clk);
            if (div_start && model_en) begin
                repeat (model_lat - 1) @(posedge clk);
                #1;
                if (ops_chk) begin
                    check("div_a_stable", {5'd0, div_a}, {5'd0, exp_a});
                    check("div_b_stable", {5'd0, div_b}, {5'd0, exp_b});
                end
                div_r    = model_r;
                div_done = 1'b1;
                @(posedge clk);
                #1;
                div_done = 1'b0;
                if (ops_chk) check("done_to_valid", {36'd0, out_valid}, 37'd1);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic [4:0] f, input logic bypass);
        int g;
        exp_q.push_back({r, f});
        n_push++;
        exp_a = a;
        exp_b = b;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 200) check("accept_timeout", {36'd0, in_ready}, 37'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (bypass) check("bypass_latency", {36'd0, out_valid}, 37'd1);
    endtask

    task automatic wait_out();
        int g;
        g = 0;
        while (n_pop < n_push && g < 300) begin
            @(negedge clk);
            g++;
        end
        check("drain", 37'(n_pop), 37'(n_push));
        @(posedge clk);
        #1;
    endtask

    logic [31:0] sp_a [10] = '{32'h3F800000, 32'h80000000, 32'hFF800000, 32'h7F000000, 32'h00800000,
                               32'h7FC00001, 32'hC0000000, 32'h00000001, 32'h7F800000, 32'h7F800000};
    logic [31:0] sp_b [10] = '{32'h00000000, 32'h80000000, 32'h40000000, 32'h00800000, 32'h40000000,
                               32'h3F800000, 32'h7F800000, 32'h3F800000, 32'h7F800000, 32'h80000000};
    logic [31:0] sp_r [10] = '{32'h7F800000, 32'h7FC00000, 32'hFF800000, 32'h7F800000, 32'h00000000,
                               32'h7FC00000, 32'h80000000, 32'h00000000, 32'h7FC00000, 32'hFF800000};
    logic [4:0]  sp_f [10] = '{5'b01000, 5'b10000, 5'b00000, 5'b00100, 5'b00010,
                               5'b10000, 5'b00000, 5'b00000, 5'b10000, 5'b00000};

    initial begin
        int s0;
        int cyc;
        int p0;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_r", {5'd0, out_r}, 37'd0);
        check("reset_ctrl", {32'd0, div_start, busy, out_valid, out_flags[1:0]}, 37'd0);
        check("reset_flags", {32'd0, out_flags}, 37'd0);
        check("reset_div_ops", {5'd0, div_a | div_b}, 37'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", {36'd0, in_ready}, 37'd1);

        model_en = 1'b1;
        model_lat = 6;
        model_r = 32'h3FC00000;
        s0 = n_starts;
        issue(32'h40400000, 32'h40000000, 32'h3FC00000, 5'b00000, 1'b0);
        wait_out();
        check("normal_one_start", 37'(n_starts - s0), 37'd1);

        s0 = n_starts;
        for (int i = 0; i < 10; i++) begin
            issue(sp_a[i], sp_b[i], sp_r[i], sp_f[i], 1'b1);
            wait_out();
        end
        check("specials_no_start", 37'(n_starts - s0), 37'd0);

        model_r = 32'h7FFFFFFF;
        issue(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'b00100, 1'b0);
        wait_out();
        model_r = 32'h00400000;
        issue(32'h00800000, 32'h3F800000, 32'h00000000, 5'b00010, 1'b0);
        wait_out();

        model_en = 1'b0;
        issue(32'h40400000, 32'h40000000, 32'h7FC00000, 5'b10001, 1'b0);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("timeout_latency", 37'(cyc), 37'd65);
        wait_out();
        div_done = 1'b1;
        div_r = 32'h3F800000;
        @(posedge clk);
        #1;
        div_done = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("late_done_ignored", {35'd0, busy, out_valid}, 37'd0);

        model_en = 1'b1;
        model_r = 32'h3FC00000;
        out_ready = 1'b0;
        issue(32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {out_r, out_flags}, {32'h7F800000, 5'b01000});
            check("bp_valid_ready", {35'd0, out_valid, in_ready}, 37'b10);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_resp", {36'd0, in_ready}, 37'd1);
        issue(32'h40400000, 32'h40000000, 32'h3FC00000, 5'b00000, 1'b0);
        wait_out();

        ops_chk = 1'b0;
        model_lat = 20;
        issue(32'h40400000, 32'h40000000, 32'h3FC00000, 5'b00000, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("busy_in_wait", {36'd0, busy}, 37'd1);
        reset_n = 1'b0;
        #1;
        check("reset_mid_wait", {34'd0, out_valid, div_start, busy}, 37'd0);
        exp_q.delete();
        n_push = n_pop;
        p0 = n_pop;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("ready_after_midreset", {36'd0, in_ready}, 37'd1);
        repeat (30) @(posedge clk);
        #1;
        check("stale_done_ignored", {35'd0, busy, out_valid}, 37'd0);
        check("no_stale_output", 37'(n_pop), 37'(p0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end expected summary before 200000");
        $fatal(1, "watchdog");
    end
endmodule
